// File: rtl/mem_arb_pkg.sv
// Shared widths and the response-tag encoding for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_tag_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the side not granted most recently wins.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_dm,
    output logic gnt_if,
    output logic gnt_dm
);

    // 1 = DM held the last grant; reset value makes the first tie go to IF.
    logic last_dm_q;
    logic last_dm_d;

    always_comb begin
        gnt_if    = rst & req_if & (~req_dm | last_dm_q);
        gnt_dm    = rst & req_dm & ~gnt_if;
        last_dm_d = last_dm_q;
        if (gnt_if) begin
            last_dm_d = 1'b0;
        end else if (gnt_dm) begin
            last_dm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dm_q <= 1'b1;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between an instruction-fetch port and a data port.
// Reads return one cycle after grant; writes commit at the grant edge.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [BE_W-1:0]   dm_w_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [BE_W-1:0]   mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    rsp_tag_e    rsp_tag_q;
    rsp_tag_e    rsp_tag_d;
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req_if (if_req),
        .req_dm (dm_req),
        .gnt_if (if_gnt),
        .gnt_dm (dm_gnt)
    );

    // Memory-side mux: the idle bus is all zeros so nothing is written by accident.
    always_comb begin
        mem_w_en  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_w_en  = dm_w_en;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_tag_q      <= RSP_NONE;
            conflict_cnt_q <= '0;
        end else begin
            rsp_tag_q      <= rsp_tag_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Next tag: only read grants expect a response in the following cycle.
    always_comb begin
        rsp_tag_d = RSP_NONE;
        if (if_gnt) begin
            rsp_tag_d = RSP_IF;
        end else if (dm_gnt && (dm_w_en == '0)) begin
            rsp_tag_d = RSP_DM;
        end
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (if_req && dm_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_comb begin
        if_rvalid    = (rsp_tag_q == RSP_IF);
        dm_rvalid    = (rsp_tag_q == RSP_DM);
        if_rdata     = mem_rdata;
        dm_rdata     = mem_rdata;
        conflict_cnt = conflict_cnt_q;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, `clk`; reset is asynchronous and active-low, port `rst` (asserted when 0).
REQ-002 Port: clk  in  1  clock.
REQ-003 Port: rst  in  1  async active-low reset.
REQ-004 Port: if_req  in  1  fetch read request; held until if_gnt.
REQ-005 Port: if_addr  in  16  fetch byte address.
REQ-006 Port: if_gnt  out  1  fetch request issued this cycle.
REQ-007 Port: if_rvalid  out  1  fetch read data valid.
REQ-008 Port: if_rdata  out  32  fetch read data.
REQ-009 Port: dm_req  in  1  data request; held with payload until dm_gnt.
REQ-010 Port: dm_w_en  in  4  byte write enables; 0 = read.
REQ-011 Port: dm_addr  in  16  data byte address.
REQ-012 Port: dm_wdata  in  32  store data.
REQ-013 Port: dm_gnt  out  1  data request issued this cycle.
REQ-014 Port: dm_rvalid  out  1  data load data valid.
REQ-015 Port: dm_rdata  out  32  load data.
REQ-016 Port: mem_w_en  out  4  shared SRAM byte write enables.
REQ-017 Port: mem_addr  out  16  shared SRAM address.
REQ-018 Port: mem_wdata  out  32  shared SRAM write data.
REQ-019 Port: mem_rdata  in  32  shared SRAM read data, valid one cycle after address.
REQ-020 Port: conflict_cnt  out  16  cycles where both requests were pending; saturates.

Function
REQ-021 At most one grant SHALL be issued per cycle; grants are combinational, single-cycle pulses.
REQ-022 If only one requester asserts req, that requester SHALL be granted in the same cycle.
REQ-023 If both assert req, the requester not granted most recently SHALL win; last_grant register updates on every grant.
REQ-024 In a grant cycle, mem_addr/mem_w_en/mem_wdata SHALL be driven from the granted requester; IF grant drives mem_w_en=0 and mem_wdata=0.
REQ-025 With no grant, mem_w_en, mem_addr and mem_wdata SHALL all be 0.
REQ-026 A read grant SHALL set a registered response tag (NONE/IF/DM); the next cycle asserts the matching rvalid for exactly one cycle.
REQ-027 A write grant (dm_w_en≠0) SHALL produce no rvalid; the write commits at the grant clock edge.
REQ-028 Back-to-back grants SHALL be allowed; a response and a new grant may occur in the same cycle.
REQ-029 if_rdata and dm_rdata SHALL equal mem_rdata combinationally, qualified only by their rvalid.
REQ-030 conflict_cnt SHALL increment by 1 on each cycle with if_req=1 and dm_req=1, and hold at 16'hFFFF.
REQ-031 Dropping req before gnt is illegal; the block SHALL ignore the dropped request without corrupting state.

Reset
REQ-032 On rst=0, the following SHALL clear immediately: response tag → NONE, last_grant → DM (first tie goes to IF), conflict_cnt → 0, all rvalid → 0.
REQ-033 Reset asserted mid-transaction SHALL drop any pending read response; no rvalid SHALL appear after release.
REQ-034 During reset, gnt outputs and mem_w_en SHALL be 0.

Structure
REQ-035 Package mem_arb_pkg SHALL hold ADDR_W=16, DATA_W=32, BE_W=4, and the response-tag enum {RSP_NONE, RSP_IF, RSP_DM}.
REQ-036 A sub-module rr_arb2 (two-input round-robin arbiter with last-grant register) SHALL implement REQ-022/023.

Verification
REQ-037 Scenario: only if_req=1, if_addr=0x0010 → if_gnt same cycle, mem_addr=0x0010, mem_w_en=0; next cycle if_rvalid=1, if_rdata=mem word.
REQ-038 Scenario: both requests in first cycle after reset → IF granted; next cycle DM granted; conflict_cnt=1.
REQ-039 Scenario: dm write, w_en=4'b0011, addr=0x0100, wdata=0xDEADBEEF → mem_w_en=0011 in the grant cycle; dm_rvalid never asserts; a later read of 0x0100 returns low half 0xBEEF.
REQ-040 Scenario: both requests held continuously for 10 cycles → grants alternate IF,DM,IF,...; each side gets 5 grants; conflict_cnt=10.
REQ-041 Scenario: DM read granted, rst=0 asserted the next cycle → dm_rvalid=0, and all counters and tags are cleared.
REQ-042 Scenario: 65540 conflict cycles → conflict_cnt=16'hFFFF.
